counter_share_arbiter: RTL and testbench
========================================

// Module: counter_share_arbiter
// PURPOSE
//  Shares one external 8-bit up counter (enable/clr/value interface) between N_REQ requesters as an interval timer.
//  Arbitrates requests, clears the counter, runs it for the granted requester's length, then reports the count.
//  Sits between the timing clients and the counter instance; the only driver of the counter's enable and clr.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  WIDTH   8  counter width; must match the counter's output width
// PORTS
//  clk        in   1            single clock, rising edge
//  reset      in   1            asynchronous, active-low reset
//  req        in   N_REQ        per-requester request level; hold until done
//  req_len    in   N_REQ*WIDTH  packed lengths, requester i at [i*WIDTH +: WIDTH]
//  grant      out  N_REQ        one-hot owner; all zero when idle
//  done       out  1            one-cycle pulse: owner's interval finished
//  aborted    out  1            valid with done: owner dropped req early
//  result     out  WIDTH        count at finish; stable until next done
//  cnt_enable out  1            to counter enable
//  cnt_clr    out  1            to counter synchronous clear
//  cnt_value  in   WIDTH        from counter output
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; grant, done, aborted, cnt_enable, cnt_clr = 0; result = 0; rr pointer = 0.
//  - FSM: IDLE -> CLEAR -> RUN -> DONE -> IDLE. All outputs registered.
//  - IDLE: if any req, pick the winner and register grant; go to CLEAR. With no req, stay in IDLE with outputs 0.
//  - CLEAR (1 cycle): cnt_clr = 1 and cnt_enable = 0. Latch the owner's req_len as len.
//    - len == 0: go to DONE with result = 0.
//    - owner req low: go to DONE with aborted = 1 and result = 0.
//    - otherwise: go to RUN.
//  - RUN: cnt_enable = 1 and cnt_clr = 0.
//    - When cnt_value == len-1 (the edge that makes the count len): go to DONE.
//    - Owner req low in RUN: drop cnt_enable that same cycle and go to DONE with aborted = 1.
//  - DONE (1 cycle): done = 1. result = cnt_value, which equals len on normal completion.
//    - cnt_enable = 0. grant is held this cycle and cleared on entry to IDLE.
//  - Latency: req to grant is 1 cycle. For len = L, grant to done is L+2 cycles.
//  - len max 2^WIDTH-1, so no wrap is possible. The counter is never enabled outside RUN.
//  - Requests arriving outside IDLE wait. An owner still requesting in IDLE re-competes under the arbitration policy.
//  - req_len changes after CLEAR are ignored.
//  - The counter's own async reset is tied to the same reset.
//  - cnt_clr and cnt_enable are never both 1.
// CONFIGURATION
//  CNT_ARB_RR_EN defined: round-robin arbitration.
//    - Search starts at owner+1 mod N_REQ.
//    - The pointer advances only in DONE.
//  CNT_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register.
// STRUCTURE
//  Package cnt_arb_pkg holds:
//    - state enum (IDLE, CLEAR, RUN, DONE)
//    - WIDTH default constant
//    - one-hot-to-index function
//  Sub-module rr_arbiter (req, ptr -> one-hot gnt) holds both policies under the macro.
//  The top block holds the FSM, len/result registers and the counter interface.
// TESTING
//  1 Single req[0], len=5: grant=0001 one cycle after req; cnt_clr for 1 cycle; cnt_enable for 5 cycles;
//    done 7 cycles after grant with result=5, aborted=0.
//  2 len=0 on req[2]: CLEAR then DONE; result=0, aborted=0, cnt_enable never 1.
//  3 req[1] len=10, drops req after 3 RUN cycles: cnt_enable falls the same cycle; done with aborted=1, result=3.
//  4 req=1111, all len=2, held: RR_EN grant order 0,1,2,3,0; without RR_EN grant order 0,0,0 (lowest index).
//  5 reset driven low mid-RUN at count 4: all outputs 0 immediately (async).
//    After release: IDLE, fresh arbitration, result=0.
//  6 len=255 on req[3]: result=255, no wrap; done exactly 257 cycles after grant.

Source files
------------

// File: rtl/cnt_arb_pkg.sv
// Shared definitions for the counter-sharing arbiter: FSM states, default counter width, one-hot decode.
package cnt_arb_pkg;

   localparam int CNT_WIDTH = 8;
   localparam int MAX_REQ   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Input is one-hot (or zero), so OR-ing the matching indices yields the position.
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot requester selection. With CNT_ARB_RR_EN the search starts at ptr and wraps;
// otherwise fixed priority, lowest index wins, and there is no ptr port. Purely combinational.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
`ifdef CNT_ARB_RR_EN
   input  logic [$clog2(N_REQ)-1:0] ptr,
`endif
   output logic [N_REQ-1:0]         gnt
);

   logic found;

`ifdef CNT_ARB_RR_EN
   localparam int IDXW = $clog2(N_REQ);

   // First pass covers indices at or above ptr; the second picks up the wrapped part.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (IDXW'(i) >= ptr)) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`else
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/counter_share_arbiter.sv
// Time-shares one external up counter among N_REQ requesters: arbitrate, clear, run for the owner's length, report.
// Build option CNT_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (lowest index).
module counter_share_arbiter
   import cnt_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_len,
   output logic [N_REQ-1:0]       grant,
   output logic                   done,
   output logic                   aborted,
   output logic [WIDTH-1:0]       result,
   output logic                   cnt_enable,
   output logic                   cnt_clr,
   input  logic [WIDTH-1:0]       cnt_value
);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] arb_gnt;
   logic [WIDTH-1:0] len_q, len_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] owner_len;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             abort_q, abort_d;
   logic             en_q, en_d;
   logic             clr_q, clr_d;
   logic             owner_req;

`ifdef CNT_ARB_RR_EN
   localparam int IDXW = $clog2(N_REQ);

   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] owner_idx;

   assign owner_idx = IDXW'(onehot_to_idx(MAX_REQ'(grant_q)));

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt)
   );
`else
   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req (req),
      .gnt (arb_gnt)
   );
`endif

   always_comb begin
      owner_len = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) owner_len = req_len[i*WIDTH +: WIDTH];
      end
   end

   assign owner_req = |(req & grant_q);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      len_d     = len_q;
      result_d  = result_q;
      abort_d   = abort_q;
      en_d      = en_q;
      clr_d     = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
`ifdef CNT_ARB_RR_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            abort_d = 1'b0;
            en_d    = 1'b0;
            if (|req) begin
               grant_d = arb_gnt;
               clr_d   = 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            len_d = owner_len;
            if (owner_len == '0) begin
               state_d = ST_DONE;
            end else if (!owner_req) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               en_d    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // An owner drop wins over completion: the enable is already gated off, so len is never reached.
            if (!owner_req) begin
               en_d    = 1'b0;
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_value == len_q - WIDTH'(1)) begin
               en_d    = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d    = 1'b1;
            aborted_d = abort_q;
            result_d  = cnt_value;
            grant_d   = '0;
            state_d   = ST_IDLE;
`ifdef CNT_ARB_RR_EN
            if (owner_idx == IDXW'(N_REQ - 1)) ptr_d = '0;
            else                               ptr_d = owner_idx + 1'b1;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         len_q     <= '0;
         result_q  <= '0;
         abort_q   <= 1'b0;
         en_q      <= 1'b0;
         clr_q     <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
`ifdef CNT_ARB_RR_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         len_q     <= len_d;
         result_q  <= result_d;
         abort_q   <= abort_d;
         en_q      <= en_d;
         clr_q     <= clr_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
`ifdef CNT_ARB_RR_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign result     = result_q;
   assign cnt_clr    = clr_q;
   // Gated by the live request so an owner drop stops the counter in the same cycle.
   assign cnt_enable = en_q & owner_req;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed and random transactions against a transaction-level model of the shared-counter arbiter.
module tb_counter_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_len;
   logic [3:0]  grant;
   logic        done;
   logic        aborted;
   logic [7:0]  result;
   logic        cnt_enable;
   logic        cnt_clr;
   logic [7:0]  cnt_value;

   int          errors = 0;
   int          checks = 0;
   int          rr_start = 0;
   logic [7:0]  last_result = 8'd0;

   always #5 clk = ~clk;

   counter_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_len    (req_len),
      .grant      (grant),
      .done       (done),
      .aborted    (aborted),
      .result     (result),
      .cnt_enable (cnt_enable),
      .cnt_clr    (cnt_clr),
      .cnt_value  (cnt_value)
   );

   // The shared external counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          cnt_value <= 8'd0;
      else if (cnt_clr)    cnt_value <= 8'd0;
      else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Winner: first requester scanning cyclically from start (start stays 0 for fixed priority).
   function automatic int pick(input logic [3:0] r, input int start);
      for (int o = 0; o < 4; o++) begin
         int idx;
         idx = (start + o) % 4;
         if (r[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [31:0] mk_lens(input int l0, input int l1, input int l2, input int l3);
      return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
   endfunction

   // Called at a negedge while the DUT is idle. abort_at: -1 none, 0 drop in CLEAR, k drop once the count is k.
   task automatic run_txn(input logic [3:0] reqv, input logic [31:0] lens, input int abort_at,
                          input bit keep, output int w);
      int L, exp_lat, exp_res, lat, en_cnt, clr_cnt, excl, gbad;
      bit exp_ab, dropped, seen;
      logic [3:0] exp_g;
      w      = pick(reqv, rr_start);
      exp_g  = 4'b0001 << w;
      L      = int'(lens[w*8 +: 8]);
      if (abort_at < 0 || L == 0) begin
         exp_lat = L + 2; exp_res = L; exp_ab = 1'b0;
      end else if (abort_at == 0) begin
         exp_lat = 2; exp_res = 0; exp_ab = 1'b1;
      end else begin
         exp_lat = abort_at + 3; exp_res = abort_at; exp_ab = 1'b1;
      end
      req     = reqv;
      req_len = lens;
      @(negedge clk);
      chk("grant_after_req", 32'(grant), 32'(exp_g));
      chk("clr_in_clear", 32'(cnt_clr), 32'd1);
      chk("en_in_clear", 32'(cnt_enable), 32'd0);
      chk("done_low_at_grant", 32'(done), 32'd0);
      chk("result_held", 32'(result), 32'(last_result));
      dropped = 1'b0; seen = 1'b0; lat = 0;
      en_cnt = 0; clr_cnt = 0; excl = 0; gbad = 0;
      if (abort_at == 0 && L > 0) begin
         req[w]  = 1'b0;
         dropped = 1'b1;
      end
      for (int c = 1; c <= L + 12 && !seen; c++) begin
         @(negedge clk);
         if (cnt_enable) en_cnt++;
         if (cnt_clr) clr_cnt++;
         if (cnt_enable && cnt_clr) excl++;
         if (done) begin
            seen = 1'b1;
            lat  = c;
         end else begin
            if (grant !== exp_g) gbad++;
            if (abort_at > 0 && !dropped && cnt_enable && cnt_value == 8'(abort_at)) begin
               req[w]  = 1'b0;
               dropped = 1'b1;
               #1;
               chk("en_drops_same_cycle", 32'(cnt_enable), 32'd0);
            end
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("grant_to_done", 32'(lat), 32'(exp_lat));
      chk("result", 32'(result), 32'(exp_res));
      chk("aborted", 32'(aborted), 32'(exp_ab));
      chk("grant_clear_idle", 32'(grant), 32'd0);
      chk("clr_single_cycle", 32'(clr_cnt), 32'd0);
      chk("clr_en_exclusive", 32'(excl), 32'd0);
      chk("grant_held", 32'(gbad), 32'd0);
      if (!exp_ab) chk("enable_cycles", 32'(en_cnt), 32'(L));
      last_result = 8'(exp_res);
`ifdef CNT_ARB_RR_EN
      rr_start = (w + 1) % 4;
`endif
      if (!keep) req[w] = 1'b0;
   endtask

   initial begin
      int w;
      bit found;
      int order [5];
      reset   = 1'b0;
      req     = '0;
      req_len = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'({grant, done, aborted, result, cnt_enable, cnt_clr}), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_no_req", 32'(grant), 32'd0);

      run_txn(4'b0001, mk_lens(5, 0, 0, 0), -1, 1'b0, w);     // basic interval
      run_txn(4'b0100, mk_lens(9, 9, 0, 9), -1, 1'b0, w);     // zero length
      run_txn(4'b0100, mk_lens(0, 0, 7, 0), 0, 1'b0, w);      // drop during CLEAR
      run_txn(4'b0010, mk_lens(0, 10, 0, 0), 3, 1'b0, w);     // drop mid-RUN at count 3
      run_txn(4'b1000, mk_lens(0, 0, 0, 255), -1, 1'b0, w);   // full range, no wrap

`ifdef CNT_ARB_RR_EN
      order = '{0, 1, 2, 3, 0};
`else
      order = '{0, 0, 0, 0, 0};
`endif
      for (int i = 0; i < 5; i++) begin
         run_txn(4'b1111, mk_lens(2, 2, 2, 2), -1, 1'b1, w);
         chk("arb_order", 32'(grant === 4'b0000 ? w : -1), 32'(order[i]));
      end

      // Asynchronous reset while counting.
      req     = 4'b0001;
      req_len = mk_lens(10, 0, 0, 0);
      found   = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (cnt_enable && cnt_value == 8'd4) found = 1'b1;
      end
      chk("reached_count4", 32'(found), 32'd1);
      #2 reset = 1'b0;
      #1 chk("async_reset_outputs", 32'({grant, done, aborted, result, cnt_enable, cnt_clr}), 32'd0);
      req = '0;
      @(negedge clk);
      reset       = 1'b1;
      rr_start    = 0;
      last_result = 8'd0;
      @(negedge clk);
      chk("idle_after_reset", 32'(grant), 32'd0);
      run_txn(4'b1001, mk_lens(3, 0, 0, 4), -1, 1'b0, w);

      for (int t = 0; t < 24; t++) begin
         logic [3:0]  rv;
         logic [31:0] lv;
         int          ab, wl, lw;
         rv = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) lv[i*8 +: 8] = 8'($urandom_range(0, 12));
         wl = pick(rv, rr_start);
         lw = int'(lv[wl*8 +: 8]);
         ab = -1;
         if (lw >= 2 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(1, lw - 1));
         else if (lw >= 1 && $urandom_range(0, 7) == 0) ab = 0;
         if ($urandom_range(0, 3) == 0) begin
            req = '0;
            @(negedge clk);
            chk("idle_no_grant", 32'(grant), 32'd0);
         end
         run_txn(rv, lv, ab, 1'($urandom_range(0, 1)), wl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
